wb_stage_pipe: RTL and testbench
================================

// Module: wb_stage_pipe
// PURPOSE
//  Parametrised MEM/WB write-back stage for the MIPS pipeline. It holds the MEM/WB pipeline register
//  and selects the write-back source: ALU result, load data or link address.
//  Load data is extracted and extended per byte/half/word in big-endian order.
//  Drives the register-file write port and a forwarding copy, and counts retired instructions.
// PARAMETERS
//  DATA_W      32  datapath width; 32 or 64
//  REG_ADDR_W  5   destination register index width
//  CNT_W       32  retired-instruction counter width
//  ZERO_REG    1   1: writes to register 0 are suppressed (wb_we forced 0)
// PORTS
//  clk               input   1           clock, rising edge
//  rst_n             input   1           asynchronous reset, active low
//  flush             input   1           kill the instruction entering this cycle; output goes invalid next cycle
//  stall             input   1           hold the MEM/WB register
//  in_valid          input   1           MEM stage presents an instruction
//  in_ready          output  1           stage can accept; = !stall (combinational)
//  in_wb_sel         input   2           0 ALU, 1 memory load, 2 link address, 3 reserved (treated as ALU)
//  in_alu_result     input   DATA_W      ALU result; also the load address
//  in_read_data      input   DATA_W      raw memory read word
//  in_link_addr      input   DATA_W      return address (PC+8) for jal/jalr
//  in_load_size      input   2           0 full word, 1 half, 2 byte, 3 reserved (treated as full word)
//  in_load_unsigned  input   1           1: zero-extend, 0: sign-extend
//  in_reg_write      input   1           instruction writes a register
//  in_dest_reg       input   REG_ADDR_W  destination register index
//  wb_valid          output  1           registered instruction valid
//  wb_we             output  1           register-file write enable
//  wb_addr           output  REG_ADDR_W  register-file write address
//  wb_out            output  DATA_W      register-file write data; also the forwarding source
//  retired_count     output  CNT_W       number of instructions retired
// BEHAVIOUR
//  Reset (rst_n low, asynchronous): wb_valid, wb_we, wb_addr, wb_out and retired_count all go to 0.
//  Accept: an instruction is accepted when in_valid & in_ready & !flush.
//  Latency: 1 cycle. Data accepted at edge N appears on wb_* after edge N.
//  Clock edge with stall=1 and flush=0: all registers hold their value.
//  flush=1 at a clock edge: wb_valid<=0 and wb_we<=0, whatever stall and in_valid are.
//    flush takes priority over stall.
//    wb_addr and wb_out are don't-care; the implementation holds them.
//  No accept, no stall, no flush: wb_valid<=0, wb_we<=0.
//  wb_we = accepted & in_reg_write & !(ZERO_REG & in_dest_reg==0), registered.
//  Load extraction (applies when in_wb_sel==1), computed combinationally before the register:
//    OFS_W = $clog2(DATA_W/8); k = in_alu_result[OFS_W-1:0]
//    byte: in_read_data[DATA_W-1-8*k -: 8]
//    half: in_read_data[DATA_W-1-16*(k>>1) -: 16]; k[0] is ignored (misaligned address, no trap)
//    word/full: in_read_data unchanged
//    Then zero- or sign-extend to DATA_W.
//  Source mux: result of the in_wb_sel decode is registered into wb_out.
//  retired_count: +1 at every edge where wb_valid is 1 and no stall holds it.
//    Each instruction is counted exactly once, when it leaves the stage; wraps modulo 2^CNT_W.
//    Flushed instructions are never counted.
//  Reset mid-operation: asynchronous clear; the in-flight instruction is lost and not counted.
// STRUCTURE
//  Package wb_pkg:
//    WB_SEL_ALU/MEM/LINK encodings; LOAD_WORD/HALF/BYTE encodings
//    function ext_load(data, ofs, size, unsigned_flag)
//  Sub-module wb_load_align: purely combinational byte/half lane select plus extension;
//    parametrised by DATA_W.
//  Top level: the pipeline register, the source mux, the enable logic and the counter.
// TESTING
//  lw: wb_sel=1, size=0, read_data=32'hDEADBEEF, dest=8
//    -> after 1 edge: wb_out=DEADBEEF, wb_we=1, wb_addr=8
//  lb signed: addr[1:0]=2'b01, read_data=32'h12_F0_34_56 -> wb_out=FFFFFFF0
//    same with lbu -> wb_out=000000F0
//  lh: addr[1:0]=2'b10, read_data=32'h1234_8001 -> lh gives FFFF8001; lhu gives 00008001
//  addi to register 0 with result=5 -> wb_valid=1, wb_we=0; retired_count increments by 1
//  jal: wb_sel=2, link=32'h0040_0010, dest=31
//    -> wb_out=00400010, wb_we=1; stall for 3 cycles -> outputs hold
//    and retired_count increments only once, after the stall
//  flush with stall=1 and in_valid=1 -> wb_valid=0 next edge, count unchanged;
//    assert rst_n low mid-stream -> all outputs 0 immediately

Source files
------------

// File: rtl/wb_pkg.sv
// Shared encodings and the load lane-select/extension helper for the MEM/WB write-back stage.
package wb_pkg;

    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'd0,
        WB_SEL_MEM  = 2'd1,
        WB_SEL_LINK = 2'd2,
        WB_SEL_RSVD = 2'd3
    } wb_sel_e;

    typedef enum logic [1:0] {
        LOAD_WORD = 2'd0,
        LOAD_HALF = 2'd1,
        LOAD_BYTE = 2'd2,
        LOAD_RSVD = 2'd3
    } load_size_e;

    localparam int unsigned MAX_DATA_W = 64;

    // Big-endian lane select: offset 0 is the most significant byte of the word.
    // data/ofs are zero-padded to the widest datapath; data_w is the real width.
    // The caller guarantees ofs < data_w/8.
    function automatic logic [MAX_DATA_W-1:0] ext_load(
        input logic [MAX_DATA_W-1:0] data,
        input logic [2:0]            ofs,
        input logic [1:0]            size,
        input logic                  unsigned_flag,
        input int unsigned           data_w
    );
        int unsigned             nbytes;
        int unsigned             ofs_i;
        int unsigned             bshift;
        int unsigned             hshift;
        logic [7:0]              b;
        logic [15:0]             h;
        logic [MAX_DATA_W-1:0]   r;
        nbytes = data_w / 8;
        ofs_i  = {29'd0, ofs};
        bshift = 8 * (nbytes - 1 - ofs_i);
        hshift = 16 * ((nbytes / 2) - 1 - (ofs_i >> 1));
        b      = 8'(data >> bshift);
        h      = 16'(data >> hshift);
        case (load_size_e'(size))
            LOAD_BYTE: r = unsigned_flag ? {56'd0, b} : {{56{b[7]}}, b};
            LOAD_HALF: r = unsigned_flag ? {48'd0, h} : {{48{h[15]}}, h};
            default:   r = data;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/wb_stage_pipe_if.sv
// MEM -> WB instruction hand-off bundle. The MEM stage is the master.
interface wb_stage_pipe_if #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
);
    import wb_pkg::*;

    // Handshake: an instruction transfers on a rising edge where in_valid and
    // in_ready are both high; in_ready never depends on in_valid, and the
    // master may change its payload freely while in_valid is low.
    logic                  in_valid;
    logic                  in_ready;
    logic [1:0]            in_wb_sel;
    logic [DATA_W-1:0]     in_alu_result;
    logic [DATA_W-1:0]     in_read_data;
    logic [DATA_W-1:0]     in_link_addr;
    logic [1:0]            in_load_size;
    logic                  in_load_unsigned;
    logic                  in_reg_write;
    logic [REG_ADDR_W-1:0] in_dest_reg;

    modport master (
        output in_valid, in_wb_sel, in_alu_result, in_read_data, in_link_addr,
               in_load_size, in_load_unsigned, in_reg_write, in_dest_reg,
        input  in_ready
    );

    modport slave (
        input  in_valid, in_wb_sel, in_alu_result, in_read_data, in_link_addr,
               in_load_size, in_load_unsigned, in_reg_write, in_dest_reg,
        output in_ready
    );

endinterface

// File: rtl/wb_load_align.sv
// Combinational load data extraction: big-endian byte/half lane select plus sign/zero extension.
module wb_load_align
    import wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int OFS_W  = $clog2(DATA_W / 8)
) (
    input  logic [DATA_W-1:0] read_data,
    input  logic [OFS_W-1:0]  ofs,
    input  logic [1:0]        load_size,
    input  logic              load_unsigned,
    output logic [DATA_W-1:0] load_data
);

    logic [MAX_DATA_W-1:0] data_wide;
    logic [2:0]            ofs_wide;
    logic [MAX_DATA_W-1:0] res_wide;
    logic                  unused_res;

    always_comb begin
        data_wide               = '0;
        data_wide[DATA_W-1:0]   = read_data;
        ofs_wide                = '0;
        ofs_wide[OFS_W-1:0]     = ofs;
        res_wide                = ext_load(data_wide, ofs_wide, load_size, load_unsigned, DATA_W);
    end

    // Extension is done at full width, so the bits above DATA_W are redundant.
    assign load_data  = res_wide[DATA_W-1:0];
    assign unused_res = ^res_wide;

endmodule

// File: rtl/wb_stage_pipe.sv
// MEM/WB pipeline register with write-back source select, register-file write port and retire counter.
module wb_stage_pipe
    import wb_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  stall,
    wb_stage_pipe_if.slave        mem,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0]     wb_out,
    output logic [CNT_W-1:0]      retired_count
);

    localparam int OFS_W = $clog2(DATA_W / 8);

    logic              accept;
    logic              zero_dest;
    logic              we_next;
    logic [DATA_W-1:0] load_data;
    logic [DATA_W-1:0] wb_data_next;

    assign mem.in_ready = !stall;
    assign accept       = mem.in_valid & mem.in_ready & !flush;
    assign zero_dest    = (ZERO_REG != 0) && (mem.in_dest_reg == '0);
    assign we_next      = mem.in_reg_write & !zero_dest;

    wb_load_align #(
        .DATA_W (DATA_W),
        .OFS_W  (OFS_W)
    ) u_load_align (
        .read_data     (mem.in_read_data),
        .ofs           (mem.in_alu_result[OFS_W-1:0]),
        .load_size     (mem.in_load_size),
        .load_unsigned (mem.in_load_unsigned),
        .load_data     (load_data)
    );

    // The reserved select code falls back to the ALU result.
    always_comb begin
        wb_data_next = mem.in_alu_result;
        case (wb_sel_e'(mem.in_wb_sel))
            WB_SEL_MEM:  wb_data_next = load_data;
            WB_SEL_LINK: wb_data_next = mem.in_link_addr;
            default:     wb_data_next = mem.in_alu_result;
        endcase
    end

    // Flush beats stall; address/data are left untouched when no instruction is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
            wb_addr  <= '0;
            wb_out   <= '0;
        end else if (flush) begin
            wb_valid <= 1'b0;
            wb_we    <= 1'b0;
        end else if (!stall) begin
            wb_valid <= accept;
            wb_we    <= accept & we_next;
            if (accept) begin
                wb_addr <= mem.in_dest_reg;
                wb_out  <= wb_data_next;
            end
        end
    end

    // An instruction retires when it leaves the register, i.e. valid and not held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retired_count <= '0;
        end else if (wb_valid && !stall) begin
            retired_count <= retired_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_wb_stage_pipe.sv
// Directed-vector bench for wb_stage_pipe (32-bit datapath, register 0 suppressed).
module tb_wb_stage_pipe;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        stall;
    logic        wb_valid;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_out;
    logic [31:0] retired_count;

    int n_vec;
    int n_err;
    logic        exp_valid;
    logic [31:0] exp_cnt;

    wb_stage_pipe_if #(.DATA_W(32), .REG_ADDR_W(5)) mem_if ();

    wb_stage_pipe #(
        .DATA_W(32), .REG_ADDR_W(5), .CNT_W(32), .ZERO_REG(1)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .stall         (stall),
        .mem           (mem_if.slave),
        .wb_valid      (wb_valid),
        .wb_we         (wb_we),
        .wb_addr       (wb_addr),
        .wb_out        (wb_out),
        .retired_count (retired_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Retire/valid tracking from the stimulus alone, updated for the coming edge.
    task automatic step();
        if (exp_valid && !stall) exp_cnt = exp_cnt + 32'd1;
        if (flush) exp_valid = 1'b0;
        else if (!stall) exp_valid = mem_if.in_valid;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] sel, input logic [31:0] alu, input logic [31:0] rd,
                         input logic [31:0] link, input logic [1:0] size, input logic uns,
                         input logic rw, input logic [4:0] dest);
        mem_if.in_valid         = 1'b1;
        mem_if.in_wb_sel        = sel;
        mem_if.in_alu_result    = alu;
        mem_if.in_read_data     = rd;
        mem_if.in_link_addr     = link;
        mem_if.in_load_size     = size;
        mem_if.in_load_unsigned = uns;
        mem_if.in_reg_write     = rw;
        mem_if.in_dest_reg      = dest;
    endtask

    task automatic check_count(input string name);
        n_vec++;
        if (retired_count !== exp_cnt) begin
            n_err++;
            $display("FAIL %s: retired_count got %0d expected %0d", name, retired_count, exp_cnt);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; stall = 1'b0;
        drive(2'd0, 32'h0, 32'h0, 32'h0, 2'd0, 1'b0, 1'b0, 5'd0);
        mem_if.in_valid = 1'b0;
        exp_valid = 1'b0; exp_cnt = 32'd0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", wb_valid); end
        n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL reset_we: got %b expected 0", wb_we); end
        n_vec++; if (wb_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr: got %h expected 00", wb_addr); end
        n_vec++; if (wb_out !== 32'h0) begin n_err++; $display("FAIL reset_out: got %h expected 00000000", wb_out); end
        check_count("reset_count");
        n_vec++; if (mem_if.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", mem_if.in_ready); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_lw();
        drive(2'd1, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0, 2'd0, 1'b0, 1'b1, 5'd8);
        step();
        n_vec++; if (wb_out !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL lw_out: got %h expected deadbeef", wb_out); end
        n_vec++; if (wb_we !== 1'b1) begin n_err++; $display("FAIL lw_we: got %b expected 1", wb_we); end
        n_vec++; if (wb_addr !== 5'd8) begin n_err++; $display("FAIL lw_addr: got %0d expected 8", wb_addr); end
        n_vec++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL lw_valid: got %b expected 1", wb_valid); end
        check_count("lw_count");
    endtask

    task automatic test_lb();
        drive(2'd1, 32'h0000_2001, 32'h12F0_3456, 32'h0, 2'd2, 1'b0, 1'b1, 5'd3);
        step();
        n_vec++; if (wb_out !== 32'hFFFF_FFF0) begin n_err++; $display("FAIL lb_out: got %h expected fffffff0", wb_out); end
        drive(2'd1, 32'h0000_2001, 32'h12F0_3456, 32'h0, 2'd2, 1'b1, 1'b1, 5'd3);
        step();
        n_vec++; if (wb_out !== 32'h0000_00F0) begin n_err++; $display("FAIL lbu_out: got %h expected 000000f0", wb_out); end
        drive(2'd1, 32'h0000_2003, 32'h12F0_3456, 32'h0, 2'd2, 1'b1, 1'b1, 5'd4);
        step();
        n_vec++; if (wb_out !== 32'h0000_0056) begin n_err++; $display("FAIL lbu_k3_out: got %h expected 00000056", wb_out); end
        drive(2'd1, 32'h0000_2000, 32'h92F0_3456, 32'h0, 2'd2, 1'b0, 1'b1, 5'd4);
        step();
        n_vec++; if (wb_out !== 32'hFFFF_FF92) begin n_err++; $display("FAIL lb_k0_out: got %h expected ffffff92", wb_out); end
        check_count("lb_count");
    endtask

    task automatic test_lh();
        drive(2'd1, 32'h0000_3002, 32'h1234_8001, 32'h0, 2'd1, 1'b0, 1'b1, 5'd5);
        step();
        n_vec++; if (wb_out !== 32'hFFFF_8001) begin n_err++; $display("FAIL lh_out: got %h expected ffff8001", wb_out); end
        drive(2'd1, 32'h0000_3002, 32'h1234_8001, 32'h0, 2'd1, 1'b1, 1'b1, 5'd5);
        step();
        n_vec++; if (wb_out !== 32'h0000_8001) begin n_err++; $display("FAIL lhu_out: got %h expected 00008001", wb_out); end
        drive(2'd1, 32'h0000_3001, 32'h9234_8001, 32'h0, 2'd1, 1'b0, 1'b1, 5'd6);
        step();
        n_vec++; if (wb_out !== 32'hFFFF_9234) begin n_err++; $display("FAIL lh_misalign_out: got %h expected ffff9234", wb_out); end
        check_count("lh_count");
    endtask

    task automatic test_zero_reg();
        drive(2'd0, 32'h0000_0005, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 5'd0);
        step();
        n_vec++; if (wb_valid !== 1'b1) begin n_err++; $display("FAIL r0_valid: got %b expected 1", wb_valid); end
        n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL r0_we: got %b expected 0", wb_we); end
        n_vec++; if (wb_out !== 32'h0000_0005) begin n_err++; $display("FAIL r0_out: got %h expected 00000005", wb_out); end
        mem_if.in_valid = 1'b0;
        step();
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL r0_idle_valid: got %b expected 0", wb_valid); end
        check_count("r0_count");
    endtask

    task automatic test_jal_stall();
        drive(2'd2, 32'h1111_1111, 32'h2222_2222, 32'h0040_0010, 2'd0, 1'b0, 1'b1, 5'd31);
        step();
        n_vec++; if (wb_out !== 32'h0040_0010) begin n_err++; $display("FAIL jal_out: got %h expected 00400010", wb_out); end
        n_vec++; if (wb_we !== 1'b1) begin n_err++; $display("FAIL jal_we: got %b expected 1", wb_we); end
        n_vec++; if (wb_addr !== 5'd31) begin n_err++; $display("FAIL jal_addr: got %0d expected 31", wb_addr); end
        // A different instruction waits at the input while the stage is held.
        drive(2'd0, 32'hAAAA_5555, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 5'd9);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_vec++; if (wb_out !== 32'h0040_0010) begin n_err++; $display("FAIL stall_out[%0d]: got %h expected 00400010", i, wb_out); end
            n_vec++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_addr !== 5'd31) begin
                n_err++; $display("FAIL stall_ctl[%0d]: got v=%b we=%b a=%0d expected v=1 we=1 a=31", i, wb_valid, wb_we, wb_addr);
            end
            n_vec++; if (mem_if.in_ready !== 1'b0) begin n_err++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, mem_if.in_ready); end
            check_count("stall_count");
        end
        stall = 1'b0;
        mem_if.in_valid = 1'b0;
        step();
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL unstall_valid: got %b expected 0", wb_valid); end
        check_count("unstall_count");
    endtask

    task automatic test_reserved_codes();
        drive(2'd3, 32'hCAFE_0001, 32'h0BAD_0BAD, 32'h0DEF_0DEF, 2'd0, 1'b0, 1'b1, 5'd2);
        step();
        n_vec++; if (wb_out !== 32'hCAFE_0001) begin n_err++; $display("FAIL sel3_out: got %h expected cafe0001", wb_out); end
        drive(2'd1, 32'h0000_0003, 32'h89AB_CDEF, 32'h0, 2'd3, 1'b0, 1'b1, 5'd2);
        step();
        n_vec++; if (wb_out !== 32'h89AB_CDEF) begin n_err++; $display("FAIL size3_out: got %h expected 89abcdef", wb_out); end
    endtask

    task automatic test_flush();
        flush = 1'b1; stall = 1'b1;
        drive(2'd0, 32'h7777_7777, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 5'd7);
        step();
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_stall_valid: got %b expected 0", wb_valid); end
        n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL flush_stall_we: got %b expected 0", wb_we); end
        check_count("flush_stall_count");
        flush = 1'b0; stall = 1'b0;
        drive(2'd0, 32'h0000_0042, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 5'd10);
        step();
        n_vec++; if (wb_valid !== 1'b1 || wb_out !== 32'h0000_0042) begin
            n_err++; $display("FAIL post_flush_accept: got v=%b out=%h expected v=1 out=00000042", wb_valid, wb_out);
        end
        flush = 1'b1;
        drive(2'd0, 32'h0000_0043, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 5'd11);
        step();
        n_vec++; if (wb_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b expected 0", wb_valid); end
        check_count("flush_count");
        flush = 1'b0;
    endtask

    task automatic test_reset_mid();
        drive(2'd0, 32'h0000_0099, 32'h0, 32'h0, 2'd0, 1'b0, 1'b1, 5'd12);
        step();
        rst_n = 1'b0;
        #2;
        n_vec++; if (wb_valid !== 1'b0 || wb_we !== 1'b0) begin
            n_err++; $display("FAIL midrst_ctl: got v=%b we=%b expected 0 0", wb_valid, wb_we);
        end
        n_vec++; if (wb_addr !== 5'd0 || wb_out !== 32'h0) begin
            n_err++; $display("FAIL midrst_data: got a=%0d out=%h expected 0 00000000", wb_addr, wb_out);
        end
        n_vec++; if (retired_count !== 32'd0) begin n_err++; $display("FAIL midrst_count: got %0d expected 0", retired_count); end
        exp_valid = 1'b0; exp_cnt = 32'd0;
        mem_if.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        step();
        check_count("after_rst_count");
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_lw();
        test_lb();
        test_lh();
        test_zero_reg();
        test_jal_stall();
        test_reserved_codes();
        test_flush();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
